// File: rtl/fir_seq_ctrl.sv
// Sequences one FIR job: AXI-Lite setup writes, stream pass-through with tlast generation, then ap_done polling.
// Latency: one write per AXI-Lite handshake pair, combinational stream pass-through, done one cycle after the ap_done read.
// Backpressure: stream ready/valid pass straight through; AXI valids are held until ready. Optional poll timeout: FIR_SEQ_POLL_TIMEOUT_EN.
module fir_seq_ctrl #(
    parameter int          MAX_TAPS  = 11,
    parameter logic [31:0] ADDR_CTRL = 32'h0000_0000,
    parameter logic [31:0] ADDR_LEN  = 32'h0000_0010,
    parameter logic [31:0] ADDR_TAPN = 32'h0000_0014,
    parameter logic [31:0] ADDR_COEF = 32'h0000_0080
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    input  logic        cmd_start,
    input  logic [31:0] cmd_len,
    input  logic [3:0]  cmd_tapn,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  coef_addr,
    input  logic [31:0] coef_rdata,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic [31:0] in_tdata,
    output logic        ss_tvalid,
    input  logic        ss_tready,
    output logic [31:0] ss_tdata,
    output logic        ss_tlast,
    input  logic        sm_tvalid,
    output logic        sm_tready,
    input  logic [31:0] sm_tdata,
    input  logic        sm_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_LEN, S_WR_TAPN, S_WR_COEF, S_WR_START, S_STREAM, S_POLL
    } state_t;

    localparam logic [31:0] MAX_TAPS_W = 32'(MAX_TAPS);

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [3:0]  tapn_q, tapn_d;
    logic [3:0]  idx_q, idx_d;
    logic        aw_acc_q, aw_acc_d;
    logic        w_acc_q, w_acc_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic        mis_q, mis_d;
    logic        rd_ph_q, rd_ph_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef FIR_SEQ_POLL_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
`endif

    logic wr_st, wr_fin, in_act, out_act, in_fire, out_fire, in_last, out_last, cmd_bad;
    logic unused_rdata;

    assign unused_rdata = ^{rdata[31:2], rdata[0]};

    assign wr_st   = (state_q == S_WR_LEN) || (state_q == S_WR_TAPN) ||
                     (state_q == S_WR_COEF) || (state_q == S_WR_START);
    assign awvalid = wr_st && !aw_acc_q;
    assign wvalid  = wr_st && !w_acc_q;
    // A write finishes once each channel has been accepted, in this cycle or earlier.
    assign wr_fin  = wr_st && (aw_acc_q || awready) && (w_acc_q || wready);

    always_comb begin
        awaddr = 32'h0;
        wdata  = 32'h0;
        case (state_q)
            S_WR_LEN:   begin awaddr = ADDR_LEN;  wdata = len_q;            end
            S_WR_TAPN:  begin awaddr = ADDR_TAPN; wdata = {28'h0, tapn_q};  end
            S_WR_COEF:  begin awaddr = ADDR_COEF + {26'h0, idx_q, 2'b00}; wdata = coef_rdata; end
            S_WR_START: begin awaddr = ADDR_CTRL; wdata = 32'h1;            end
            default:    ;
        endcase
    end

    assign in_last    = (in_cnt_q == len_q - 32'd1);
    assign out_last   = (out_cnt_q == len_q - 32'd1);
    assign in_act     = (state_q == S_STREAM) && (in_cnt_q < len_q);
    assign out_act    = (state_q == S_STREAM) && (out_cnt_q < len_q);
    assign ss_tvalid  = in_act && in_tvalid;
    assign in_tready  = in_act && ss_tready;
    assign ss_tdata   = in_tdata;
    assign ss_tlast   = in_act && in_last;
    assign out_tvalid = out_act && sm_tvalid;
    assign sm_tready  = out_act && out_tready;
    assign out_tdata  = sm_tdata;
    assign out_tlast  = out_act && out_last;
    assign in_fire    = in_act && in_tvalid && ss_tready;
    assign out_fire   = out_act && sm_tvalid && out_tready;

    assign arvalid   = (state_q == S_POLL) && !rd_ph_q;
    assign rready    = (state_q == S_POLL) && rd_ph_q;
    assign araddr    = arvalid ? ADDR_CTRL : 32'h0;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign coef_addr = idx_q;
    assign cmd_bad   = (cmd_len == 32'd0) || (cmd_tapn == 4'd0) || ({28'h0, cmd_tapn} > MAX_TAPS_W);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        tapn_d    = tapn_q;
        idx_d     = idx_q;
        aw_acc_d  = aw_acc_q;
        w_acc_d   = w_acc_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        mis_d     = mis_q;
        rd_ph_d   = rd_ph_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef FIR_SEQ_POLL_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        if (wr_fin) begin
            aw_acc_d = 1'b0;
            w_acc_d  = 1'b0;
        end else begin
            if (awvalid && awready) aw_acc_d = 1'b1;
            if (wvalid && wready)   w_acc_d  = 1'b1;
        end
        if (in_fire) in_cnt_d = in_cnt_q + 32'd1;
        if (out_fire) begin
            out_cnt_d = out_cnt_q + 32'd1;
            // Upstream tlast is only audited; the generated one is what goes downstream.
            if (sm_tlast != out_last) mis_d = 1'b1;
        end
        case (state_q)
            S_IDLE: if (cmd_start) begin
                len_d  = cmd_len;
                tapn_d = cmd_tapn;
                if (cmd_bad) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    state_d   = S_WR_LEN;
                    idx_d     = 4'd0;
                    in_cnt_d  = 32'd0;
                    out_cnt_d = 32'd0;
                    mis_d     = 1'b0;
`ifdef FIR_SEQ_POLL_TIMEOUT_EN
                    to_cnt_d  = 16'd0;
`endif
                end
            end
            S_WR_LEN:   if (wr_fin) state_d = S_WR_TAPN;
            S_WR_TAPN:  if (wr_fin) state_d = S_WR_COEF;
            S_WR_COEF:  if (wr_fin) begin
                if (idx_q == tapn_q - 4'd1) state_d = S_WR_START;
                else                        idx_d   = idx_q + 4'd1;
            end
            S_WR_START: if (wr_fin) state_d = S_STREAM;
            S_STREAM: if (in_cnt_q == len_q && out_cnt_q == len_q) begin
                state_d = S_POLL;
                rd_ph_d = 1'b0;
            end
            S_POLL: begin
                if (!rd_ph_q) begin
                    if (arready) rd_ph_d = 1'b1;
                end else if (rvalid) begin
                    rd_ph_d = 1'b0;
                    if (rdata[1]) begin
                        done_d  = 1'b1;
                        err_d   = mis_q;
                        mis_d   = 1'b0;
                        state_d = S_IDLE;
                    end
`ifdef FIR_SEQ_POLL_TIMEOUT_EN
                    else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                        if (to_cnt_q == 16'hFFFE) begin
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            mis_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= 32'd0;
            tapn_q    <= 4'd0;
            idx_q     <= 4'd0;
            aw_acc_q  <= 1'b0;
            w_acc_q   <= 1'b0;
            in_cnt_q  <= 32'd0;
            out_cnt_q <= 32'd0;
            mis_q     <= 1'b0;
            rd_ph_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef FIR_SEQ_POLL_TIMEOUT_EN
            to_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            tapn_q    <= tapn_d;
            idx_q     <= idx_d;
            aw_acc_q  <= aw_acc_d;
            w_acc_q   <= w_acc_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            mis_q     <= mis_d;
            rd_ph_q   <= rd_ph_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef FIR_SEQ_POLL_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: directed jobs push expected writes, beats and done/err; negedge monitors compare.
module tb_fir_seq_ctrl;
    localparam logic [31:0] FIR_XOR = 32'h5A5A_0000;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        cmd_start;
    logic [31:0] cmd_len;
    logic [3:0]  cmd_tapn;
    logic        busy, done, err;
    logic [3:0]  coef_addr;
    logic [31:0] coef_rdata;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        in_tvalid, in_tready, ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] in_tdata, ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast, out_tvalid, out_tready, out_tlast;
    logic [31:0] sm_tdata, out_tdata;

    always #5 axis_clk = ~axis_clk;

    fir_seq_ctrl dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_tapn(cmd_tapn),
        .busy(busy), .done(done), .err(err),
        .coef_addr(coef_addr), .coef_rdata(coef_rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast)
    );

    assign coef_rdata = 32'hC0E0_0000 + 32'(coef_addr) * 32'd17;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_wa[$], exp_wd[$], aw_seen[$], w_seen[$], fir_q[$];
    logic [32:0] exp_ss[$], exp_out[$];
    logic        exp_err[$];

    int          src_len = 0, src_idx = 0, fir_last_idx = 0, sm_cnt = 0;
    int          rd_cnt = 0, ar_cnt = 0, aw_wait = 0, aw_delay = 0;
    logic [31:0] src_base = 32'h0, ss_cap = 32'h0;
    bit          rnd_mode = 1'b0;
    bit          in_hs_f = 1'b0, ss_hs_f = 1'b0, sm_hs_f = 1'b0, ar_hs_f = 1'b0, r_hs_f = 1'b0, aw_hs_f = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitors: sample mid-cycle, record handshakes for the models, score against queues.
    always @(negedge axis_clk) begin : mon
        logic [32:0] e;
        logic [31:0] a, d;
        if (awvalid && awready) begin aw_seen.push_back(awaddr); aw_hs_f = 1'b1; end
        else if (awvalid) aw_wait++;
        if (wvalid && wready) w_seen.push_back(wdata);
        while (aw_seen.size() > 0 && w_seen.size() > 0) begin
            a = aw_seen.pop_front();
            d = w_seen.pop_front();
            if (exp_wa.size() == 0) fail_now("axi_write", $sformatf("unexpected write 0x%0h=0x%0h", a, d));
            else begin
                chk("wr_addr", a, exp_wa.pop_front());
                chk("wr_data", d, exp_wd.pop_front());
            end
        end
        if (ss_tvalid && ss_tready) begin
            ss_hs_f = 1'b1;
            ss_cap  = ss_tdata;
            if (exp_ss.size() == 0) fail_now("ss_beat", $sformatf("unexpected beat 0x%0h", ss_tdata));
            else begin
                e = exp_ss.pop_front();
                chk("ss_data", ss_tdata, e[31:0]);
                chk("ss_last", 32'(ss_tlast), 32'(e[32]));
            end
        end
        in_hs_f = in_tvalid && in_tready;
        sm_hs_f = sm_tvalid && sm_tready;
        if (out_tvalid && out_tready) begin
            if (exp_out.size() == 0) fail_now("out_beat", $sformatf("unexpected beat 0x%0h", out_tdata));
            else begin
                e = exp_out.pop_front();
                chk("out_data", out_tdata, e[31:0]);
                chk("out_last", 32'(out_tlast), 32'(e[32]));
            end
        end
        if (arvalid && arready) begin
            ar_hs_f = 1'b1;
            ar_cnt++;
            chk("araddr", araddr, 32'h0);
        end
        r_hs_f = rvalid && rready;
        if (done) begin
            if (exp_err.size() == 0) fail_now("done", $sformatf("unexpected done pulse, err=%0b", err));
            else chk("done_err", 32'(err), 32'(exp_err.pop_front()));
        end
    end

    // Bench models: FIR (echo ^ FIR_XOR), upstream source, AXI-Lite slaves.
    always @(posedge axis_clk) begin
        #1;
        if (sm_hs_f && fir_q.size() > 0) begin void'(fir_q.pop_front()); sm_cnt++; end
        if (ss_hs_f) fir_q.push_back(ss_cap);
        sm_tvalid = (fir_q.size() > 0);
        sm_tdata  = sm_tvalid ? (fir_q[0] ^ FIR_XOR) : 32'h0;
        sm_tlast  = sm_tvalid && (sm_cnt == fir_last_idx);
        if (in_hs_f) src_idx++;
        if (!in_tvalid || in_hs_f)
            in_tvalid = (src_idx < src_len) && (!rnd_mode || $urandom_range(0, 1) == 1);
        in_tdata   = src_base + 32'(src_idx) * 32'd3;
        ss_tready  = !rnd_mode || ($urandom_range(0, 2) != 0);
        out_tready = !rnd_mode || ($urandom_range(0, 2) != 0);
        if (r_hs_f) rvalid = 1'b0;
        if (ar_hs_f) begin
            rvalid = 1'b1;
            rdata  = (rd_cnt >= 1) ? 32'h2 : 32'h0;
            rd_cnt++;
        end
        if (aw_hs_f) aw_wait = 0;
        awready = (aw_wait >= aw_delay);
        {in_hs_f, ss_hs_f, sm_hs_f, ar_hs_f, r_hs_f, aw_hs_f} = '0;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({busy, done, err, awvalid, wvalid, arvalid, rready, in_tready,
                                 ss_tvalid, ss_tlast, sm_tready, out_tvalid, out_tlast}), 32'h0);
        chk({tag, "_awaddr"}, awaddr, 32'h0);
        chk({tag, "_coef_addr"}, 32'(coef_addr), 32'h0);
    endtask

    task automatic start_job(input int len, input logic [3:0] tapn, input int last_idx,
                             input bit rnd, input int awd, input bit exp_e, input logic [31:0] base);
        src_len = len; src_idx = 0; src_base = base; fir_last_idx = last_idx;
        sm_cnt = 0; rd_cnt = 0; ar_cnt = 0; aw_delay = awd; rnd_mode = rnd;
        exp_wa.push_back(32'h10); exp_wd.push_back(32'(len));
        exp_wa.push_back(32'h14); exp_wd.push_back(32'(tapn));
        for (int i = 0; i < int'(tapn); i++) begin
            exp_wa.push_back(32'h80 + 32'(i) * 32'd4);
            exp_wd.push_back(32'hC0E0_0000 + 32'(i) * 32'd17);
        end
        exp_wa.push_back(32'h00); exp_wd.push_back(32'h1);
        for (int i = 0; i < len; i++) begin
            exp_ss.push_back({i == len - 1, base + 32'(i) * 32'd3});
            exp_out.push_back({i == len - 1, (base + 32'(i) * 32'd3) ^ FIR_XOR});
        end
        exp_err.push_back(exp_e);
        cmd_len = 32'(len); cmd_tapn = tapn; cmd_start = 1'b1;
        @(posedge axis_clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic run_job(input int len, input logic [3:0] tapn, input int last_idx,
                           input bit rnd, input int awd, input bit exp_e, input bit inject,
                           input logic [31:0] base);
        bit got = 1'b0;
        bit injected = 1'b0;
        start_job(len, tapn, last_idx, rnd, awd, exp_e, base);
        for (int c = 0; c < 5000 && !got; c++) begin
            @(negedge axis_clk);
            cmd_start = 1'b0;
            if (inject && !injected && src_idx >= 5) begin
                chk("busy_at_second_cmd", 32'(busy), 32'h1);
                cmd_len = 32'd3; cmd_tapn = 4'd2; cmd_start = 1'b1;
                injected = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                chk("busy_at_done", 32'(busy), 32'h0);
            end
        end
        cmd_start = 1'b0;
        if (!got) fail_now("job_done", "no done pulse within 5000 cycles");
        @(posedge axis_clk); #1;
        chk("writes_left", 32'(exp_wa.size()), 32'h0);
        chk("ss_left", 32'(exp_ss.size()), 32'h0);
        chk("out_left", 32'(exp_out.size()), 32'h0);
        chk("done_left", 32'(exp_err.size()), 32'h0);
        chk("poll_reads", 32'(ar_cnt), 32'h2);
    endtask

    task automatic reject(input logic [31:0] len, input logic [3:0] tapn);
        exp_err.push_back(1'b1);
        cmd_len = len; cmd_tapn = tapn; cmd_start = 1'b1;
        @(posedge axis_clk); #1;
        cmd_start = 1'b0;
        @(negedge axis_clk);
        chk("reject_done", 32'(done), 32'h1);
        chk("reject_err", 32'(err), 32'h1);
        chk("reject_busy", 32'(busy), 32'h0);
        repeat (4) @(posedge axis_clk);
        #1;
        chk("reject_no_write", 32'(awvalid | wvalid), 32'h0);
        chk("reject_done_left", 32'(exp_err.size()), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        axis_rst_n = 1'b0; cmd_start = 1'b0; cmd_len = 32'h0; cmd_tapn = 4'h0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1; rvalid = 1'b0; rdata = 32'h0;
        in_tvalid = 1'b0; in_tdata = 32'h0; ss_tready = 1'b1; out_tready = 1'b1;
        sm_tvalid = 1'b0; sm_tdata = 32'h0; sm_tlast = 1'b0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check_all_zero("reset");
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;

        run_job(64, 4'd11, 63, 1'b0, 0, 1'b0, 1'b0, 32'h0000_1000);
        run_job(64, 4'd11, 63, 1'b0, 3, 1'b0, 1'b0, 32'h0002_0000);
        reject(32'd0, 4'd5);
        reject(32'd10, 4'd12);
        run_job(16, 4'd4, 9, 1'b0, 0, 1'b1, 1'b0, 32'h0030_0000);
        run_job(24, 4'd3, 23, 1'b1, 0, 1'b0, 1'b1, 32'h0400_0000);

        start_job(8, 4'd11, 7, 1'b0, 0, 1'b0, 32'h0050_0000);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge axis_clk);
            if (awvalid && awaddr == 32'h90) seen = 1'b1;
        end
        if (!seen) fail_now("reach_wr_coef", "coefficient 4 write never seen");
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b0;
        @(posedge axis_clk);
        @(negedge axis_clk);
        check_all_zero("midjob_reset");
        exp_wa.delete(); exp_wd.delete(); aw_seen.delete(); w_seen.delete();
        exp_ss.delete(); exp_out.delete(); exp_err.delete(); fir_q.delete();
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        repeat (3) @(posedge axis_clk);
        #1;
        run_job(8, 4'd2, 7, 1'b0, 0, 1'b0, 1'b0, 32'h0600_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
